// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph set, scan-decoder FSM states, sample payload and helpers.
package seg7_pkg;

    localparam int unsigned SEG7_MAX_DIGITS = 8;
    localparam int unsigned SEG7_CNT_W      = 4;
    localparam int unsigned SEG7_IDX_W      = 3;

    // Segment a is bit 0, g is bit 6.
    localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'h67;
    localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG7_GLYPH_F = 7'h71;
    localparam logic [6:0] SEG7_BLANK   = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } seg7_state_t;

    // One registered bus sample; digit select zero-extended to the widest supported bus.
    typedef struct packed {
        logic [SEG7_MAX_DIGITS-1:0] dig;
        logic [7:0]                 seg;
    } seg7_sample_t;

    function automatic logic seg7_is_onehot(input logic [SEG7_MAX_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - SEG7_MAX_DIGITS'(1))) == '0);
    endfunction

    // OR of set-bit positions; exact for one-hot inputs.
    function automatic logic [SEG7_IDX_W-1:0] seg7_onehot_idx(input logic [SEG7_MAX_DIGITS-1:0] v);
        logic [SEG7_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < SEG7_MAX_DIGITS; i++) begin
            if (v[i]) begin
                idx = idx | SEG7_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_glyph_decode.sv
// seg7_glyph_decode: combinational 7-bit segment pattern to {is_hex, is_blank, nibble}.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       is_hex_c,
    output logic       is_blank_c,
    output logic [3:0] nibble_c
);

    always_comb begin
        is_hex_c   = 1'b1;
        is_blank_c = (pattern == SEG7_BLANK);
        nibble_c   = 4'h0;
        case (pattern)
            SEG7_GLYPH_0: nibble_c = 4'h0;
            SEG7_GLYPH_1: nibble_c = 4'h1;
            SEG7_GLYPH_2: nibble_c = 4'h2;
            SEG7_GLYPH_3: nibble_c = 4'h3;
            SEG7_GLYPH_4: nibble_c = 4'h4;
            SEG7_GLYPH_5: nibble_c = 4'h5;
            SEG7_GLYPH_6: nibble_c = 4'h6;
            SEG7_GLYPH_7: nibble_c = 4'h7;
            SEG7_GLYPH_8: nibble_c = 4'h8;
            SEG7_GLYPH_9: nibble_c = 4'h9;
            SEG7_GLYPH_A: nibble_c = 4'hA;
            SEG7_GLYPH_B: nibble_c = 4'hB;
            SEG7_GLYPH_C: nibble_c = 4'hC;
            SEG7_GLYPH_D: nibble_c = 4'hD;
            SEG7_GLYPH_E: nibble_c = 4'hE;
            SEG7_GLYPH_F: nibble_c = 4'hF;
            default:      is_hex_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounces a scanned 7-segment bus and recovers each digit's hex nibble.
// Optional feature macro SEG7_DP_EN: capture the decimal point per digit and include it in the stability compare.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [7:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   value_o,
    output logic [NUM_DIGITS-1:0]     blank_o,
    output logic [NUM_DIGITS-1:0]     dp_o,
    output logic                      valid_o,
    output logic [SEG7_IDX_W-1:0]     digit_idx_o,
    output logic                      err_o,
    output logic [7:0]                err_cnt_o,
    output logic                      frame_o
);

    localparam logic [SEG7_CNT_W-1:0] CNT_ONE    = SEG7_CNT_W'(1);
    localparam logic [SEG7_CNT_W-1:0] CNT_TARGET = SEG7_CNT_W'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = '1;

    seg7_sample_t          s_d;
    seg7_sample_t          s_q;
    seg7_sample_t          s_prev_q;
    seg7_state_t           state_q;
    seg7_state_t           state_d;
    logic [SEG7_CNT_W-1:0] cnt_q;
    logic [SEG7_CNT_W-1:0] cnt_d;
    logic                  accept;
    logic                  sample_ok;
    logic                  changed;
    logic                  is_hex;
    logic                  is_blank;
    logic [3:0]            nibble;
    logic                  good_glyph;
    logic [NUM_DIGITS-1:0] dig_hit;
    logic [NUM_DIGITS-1:0] acc_bits;
    logic [NUM_DIGITS-1:0] frame_mask_q;
    logic [SEG7_IDX_W-1:0] dig_idx;

    // Input sample; without the DP feature bit7 is dropped so it cannot disturb the debounce.
    always_comb begin
        s_d         = '0;
        s_d.dig     = SEG7_MAX_DIGITS'(dig_sel);
`ifdef SEG7_DP_EN
        s_d.seg     = seg_in;
`else
        s_d.seg     = {1'b0, seg_in[6:0]};
`endif
    end

    seg7_glyph_decode u_glyph (
        .pattern    (s_q.seg[6:0]),
        .is_hex_c   (is_hex),
        .is_blank_c (is_blank),
        .nibble_c   (nibble)
    );

    assign dig_hit    = s_q.dig[NUM_DIGITS-1:0];
    assign dig_idx    = seg7_onehot_idx(s_q.dig);
    assign good_glyph = is_hex || is_blank;
    assign acc_bits   = (accept && good_glyph) ? dig_hit : '0;

    // State, debounce counter and sample history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            s_prev_q <= s_q;
        end
    end

    // Next state: a sample must be one-hot and enabled to be tracked; any change restarts the count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        sample_ok = seg7_is_onehot(s_q.dig) && ena;
        changed   = (s_q != s_prev_q);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sample_ok) begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_TRACK: begin
                if (!sample_ok) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q + CNT_ONE == CNT_TARGET) begin
                    accept  = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!sample_ok) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Digit bank, strobes, error counter and frame mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_o      <= '0;
            blank_o      <= '0;
            valid_o      <= 1'b0;
            digit_idx_o  <= '0;
            err_o        <= 1'b0;
            err_cnt_o    <= '0;
            frame_o      <= 1'b0;
            frame_mask_q <= '0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (accept) begin
                digit_idx_o <= dig_idx;
                if (good_glyph) begin
                    valid_o <= 1'b1;
                end else begin
                    err_o <= 1'b1;
                    if (err_cnt_o != 8'hFF) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    if (dig_hit[k]) begin
                        if (is_hex) begin
                            value_o[4*k +: 4] <= nibble;
                            blank_o[k]        <= 1'b0;
                        end else if (is_blank) begin
                            blank_o[k] <= 1'b1;
                        end
                    end
                end
            end
            // A completed frame restarts the mask, keeping any digit accepted on this same edge.
            if (frame_mask_q == ALL_DIGITS) begin
                frame_o      <= 1'b1;
                frame_mask_q <= acc_bits;
            end else begin
                frame_o      <= 1'b0;
                frame_mask_q <= frame_mask_q | acc_bits;
            end
        end
    end

`ifdef SEG7_DP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_o <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (acc_bits[k]) begin
                    dp_o[k] <= s_q.seg[7];
                end
            end
        end
    end
`else
    logic unused_dp;
    assign unused_dp = seg_in[7];
    assign dp_o      = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed steps then randomized scanning against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [7:0]        seg_in;
    logic [ND-1:0]     dig_sel;
    logic [4*ND-1:0]   value_o;
    logic [ND-1:0]     blank_o;
    logic [ND-1:0]     dp_o;
    logic              valid_o;
    logic [2:0]        digit_idx_o;
    logic              err_o;
    logic [7:0]        err_cnt_o;
    logic              frame_o;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value_o     (value_o),
        .blank_o     (blank_o),
        .dp_o        (dp_o),
        .valid_o     (valid_o),
        .digit_idx_o (digit_idx_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o),
        .frame_o     (frame_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_valid, cnt_err, cnt_frame;

    logic [6:0] glyph [16];

    // Reference model: registered sample, run length of identical valid samples, digit bank.
    logic [ND-1:0]   m_dig, m_dig_prev;
    logic [7:0]      m_seg, m_seg_prev;
    int              m_run;
    logic [4*ND-1:0] m_value;
    logic [ND-1:0]   m_blank, m_dp, m_mask;
    logic            m_valid, m_err, m_frame;
    logic [2:0]      m_idx;
    int              m_errcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [ND-1:0] acc_bits;
        int k, nib;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_frame  = 1'b0;
        acc_bits = '0;
        if (!rst_n) begin
            m_dig = '0; m_dig_prev = '0; m_seg = '0; m_seg_prev = '0; m_run = 0;
            m_value = '0; m_blank = '0; m_dp = '0; m_mask = '0; m_idx = '0; m_errcnt = 0;
        end else begin
            if (!ena || $countones(m_dig) != 1) m_run = 0;
            else if (m_run > 0 && m_dig == m_dig_prev && m_seg == m_seg_prev) m_run++;
            else m_run = 1;
            if (m_run == SC) begin
                k = 0;
                for (int i = 0; i < ND; i++) if (m_dig[i]) k = i;
                m_idx = 3'(k);
                nib = -1;
                for (int j = 0; j < 16; j++) if (glyph[j] == m_seg[6:0]) nib = j;
                if (nib >= 0) begin
                    m_value[4*k +: 4] = 4'(nib);
                    m_blank[k] = 1'b0;
                    m_valid = 1'b1;
                end else if (m_seg[6:0] == 7'h00) begin
                    m_blank[k] = 1'b1;
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                    if (m_errcnt < 255) m_errcnt++;
                end
                if (m_valid) begin
                    acc_bits[k] = 1'b1;
                    m_dp[k] = m_seg[7];
                end
            end
            if (&m_mask) begin
                m_frame = 1'b1;
                m_mask  = acc_bits;
            end else begin
                m_mask = m_mask | acc_bits;
            end
            m_dig_prev = m_dig;
            m_seg_prev = m_seg;
            m_dig = dig_sel;
`ifdef SEG7_DP_EN
            m_seg = seg_in;
`else
            m_seg = {1'b0, seg_in[6:0]};
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cnt_valid += int'(valid_o);
        cnt_err   += int'(err_o);
        cnt_frame += int'(frame_o);
        chk("valid", 32'(valid_o), 32'(m_valid));
        chk("err", 32'(err_o), 32'(m_err));
        chk("frame", 32'(frame_o), 32'(m_frame));
        chk("digit_idx", 32'(digit_idx_o), 32'(m_idx));
        chk("value", 32'(value_o), 32'(m_value));
        chk("blank", 32'(blank_o), 32'(m_blank));
        chk("err_cnt", 32'(err_cnt_o), 32'(m_errcnt));
`ifdef SEG7_DP_EN
        chk("dp", 32'(dp_o), 32'(m_dp));
`else
        chk("dp", 32'(dp_o), 32'd0);
`endif
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        cnt_valid = 0;
        cnt_err   = 0;
        cnt_frame = 0;
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_dig = '0; m_dig_prev = '0; m_seg = '0; m_seg_prev = '0; m_run = 0;
        m_value = '0; m_blank = '0; m_dp = '0; m_mask = '0; m_idx = '0; m_errcnt = 0;
        clr_counts();

        // Reset with random inputs.
        rst_n   = 1'b0;
        ena     = 1'($urandom);
        seg_in  = 8'($urandom);
        dig_sel = ND'($urandom);
        tick();
        seg_in  = 8'($urandom);
        dig_sel = ND'($urandom);
        tick();
        chk("rst_value", 32'(value_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst_blank", 32'(blank_o), 32'd0);
        rst_n = 1'b1; ena = 1'b1; seg_in = 8'h00; dig_sel = '0;
        hold(2);

        // Single capture with latency STABLE_CYCLES+1.
        clr_counts();
        dig_sel = 4'b0001; seg_in = 8'h5B;
        hold(4);
        chk("t2_not_early", 32'(cnt_valid), 32'd0);
        tick();
        chk("t2_valid_now", 32'(valid_o), 32'd1);
        chk("t2_value", 32'(value_o[3:0]), 32'd2);
        chk("t2_idx", 32'(digit_idx_o), 32'd0);
        hold(5);
        chk("t2_single_pulse", 32'(cnt_valid), 32'd1);

        // Short-lived pattern is not captured.
        clr_counts();
        seg_in = 8'h4F; hold(3);
        seg_in = 8'h66; hold(5);
        chk("t3_one_capture", 32'(cnt_valid), 32'd1);
        chk("t3_value", 32'(value_o[3:0]), 32'd4);

        // Non-hex glyph raises an error and leaves the bank alone; counter saturates.
        clr_counts();
        dig_sel = 4'b0010; seg_in = 8'h12; hold(6);
        chk("t4_err_pulse", 32'(cnt_err), 32'd1);
        chk("t4_err_cnt", 32'(err_cnt_o), 32'd1);
        chk("t4_value_hi", 32'(value_o[7:4]), 32'd0);
        for (int i = 0; i < 255; i++) begin
            seg_in = (i % 2 == 0) ? 8'h13 : 8'h12;
            hold(5);
        end
        chk("t4_err_sat", 32'(err_cnt_o), 32'd255);

        // Full scan of all digits produces one frame strobe.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        clr_counts();
        dig_sel = 4'b0001; seg_in = 8'h3F; hold(6);
        dig_sel = 4'b0010; seg_in = 8'h06; hold(6);
        dig_sel = 4'b0100; seg_in = 8'h7C; hold(6);
        dig_sel = 4'b1000; seg_in = 8'h71; hold(6);
        dig_sel = 4'b0000; hold(3);
        chk("t5_value", 32'(value_o), 32'hFB10);
        chk("t5_frames", 32'(cnt_frame), 32'd1);
        chk("t5_valids", 32'(cnt_valid), 32'd4);

        // Multi-hot select and dropped enable suppress capture.
        clr_counts();
        dig_sel = 4'b0011; seg_in = 8'h06; hold(8);
        dig_sel = 4'b0100; seg_in = 8'h5B; hold(2);
        ena = 1'b0; hold(6);
        chk("t6_no_strobe", 32'(cnt_valid + cnt_err), 32'd0);
        ena = 1'b1;
        dig_sel = 4'b1000; seg_in = 8'h86; hold(6);
        chk("t6_dp_value", 32'(value_o[15:12]), 32'd1);
`ifdef SEG7_DP_EN
        chk("t6_dp_bit", 32'(dp_o[3]), 32'd1);
`else
        chk("t6_dp_bit", 32'(dp_o[3]), 32'd0);
`endif

        // Randomized scanning: mostly one-hot selects and hex glyphs, with blanks, junk and enable drops.
        for (int s = 0; s < 300; s++) begin
            int len;
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 8) dig_sel = ND'(1) << $urandom_range(0, ND - 1);
            else dig_sel = ND'($urandom);
            pick = int'($urandom_range(0, 9));
            if (pick < 6) seg_in = {1'($urandom), glyph[$urandom_range(0, 15)]};
            else if (pick < 7) seg_in = {1'($urandom), 7'h00};
            else seg_in = 8'($urandom);
            len = int'($urandom_range(1, 8));
            for (int c = 0; c < len; c++) begin
                ena = ($urandom_range(0, 15) != 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
